// File: rtl/io_port.sv
// Memory-mapped CPU I/O port: 1-word input buffer and 1-word output buffer.
// Define IO_PORT_OUTFIFO_EN to replace the output buffer with a 4-entry FIFO.
module io_port (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_sig,
   input  logic        out_sig,
   input  logic [15:0] wr_data,
   output logic [15:0] rd_data,
   output logic        stall,
   input  logic [15:0] ext_in_data,
   input  logic        ext_in_valid,
   output logic        ext_in_ready,
   output logic [15:0] ext_out_data,
   output logic        ext_out_valid,
   input  logic        ext_out_ready
);

   logic        in_full_q, in_full_d;
   logic [15:0] in_buf_q, in_buf_d;
   logic        write_accept;
   logic        in_stall, out_stall;
   logic        in_xfer, in_consume;
   logic        out_push, out_pop;

   // A stall from either side blocks the other side's commit as well.
   always_comb begin
      in_stall     = in_sig & ~in_full_q;
      out_stall    = out_sig & ~write_accept;
      stall        = rst_n & (in_stall | out_stall);
      ext_in_ready = rst_n & (~in_full_q | (in_sig & in_full_q & ~out_stall));
      in_xfer      = ext_in_valid & ext_in_ready;
      in_consume   = in_sig & in_full_q & ~out_stall;
      out_push     = out_sig & write_accept & ~in_stall;
      rd_data      = (in_sig & in_full_q) ? in_buf_q : 16'h0000;
   end

   always_comb begin
      in_full_d = in_full_q;
      in_buf_d  = in_buf_q;
      if (in_xfer) begin
         in_full_d = 1'b1;
         in_buf_d  = ext_in_data;
      end else if (in_consume) begin
         in_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_full_q <= 1'b0;
         in_buf_q  <= 16'h0000;
      end else begin
         in_full_q <= in_full_d;
         in_buf_q  <= in_buf_d;
      end
   end

`ifdef IO_PORT_OUTFIFO_EN
   logic [15:0] mem_q [4];
   logic [15:0] mem_d [4];
   logic [1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [2:0]  cnt_q, cnt_d;

   always_comb begin
      write_accept  = (cnt_q != 3'd4) | ext_out_ready;
      out_pop       = (cnt_q != 3'd0) & ext_out_ready;
      ext_out_valid = (cnt_q != 3'd0);
      ext_out_data  = mem_q[rptr_q];
   end

   // Push at count 4 with a pop overwrites the slot being read out this cycle.
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (out_push) begin
         mem_d[wptr_q] = wr_data;
         wptr_d        = wptr_q + 2'd1;
      end
      if (out_pop) begin
         rptr_d = rptr_q + 2'd1;
      end
      if (out_push && !out_pop) begin
         cnt_d = cnt_q + 3'd1;
      end else if (!out_push && out_pop) begin
         cnt_d = cnt_q - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= 16'h0000;
         end
         wptr_q <= 2'd0;
         rptr_q <= 2'd0;
         cnt_q  <= 3'd0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end
`else
   logic        out_full_q, out_full_d;
   logic [15:0] out_buf_q, out_buf_d;

   always_comb begin
      write_accept  = ~out_full_q | ext_out_ready;
      out_pop       = out_full_q & ext_out_ready;
      ext_out_valid = out_full_q;
      ext_out_data  = out_buf_q;
   end

   always_comb begin
      out_full_d = out_full_q;
      out_buf_d  = out_buf_q;
      if (out_push) begin
         out_full_d = 1'b1;
         out_buf_d  = wr_data;
      end else if (out_pop) begin
         out_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_full_q <= 1'b0;
         out_buf_q  <= 16'h0000;
      end else begin
         out_full_q <= out_full_d;
         out_buf_q  <= out_buf_d;
      end
   end
`endif

endmodule

// File: doc/io_port.md
IO_PORT -- requirements
Module: io_port

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk rises, rst_n low resets immediately regardless of clk.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_sig  input  1  decoded CPU read of input port (address 1024), from the memory controller.
REQ-005 out_sig  input  1  decoded CPU write of output port (address 1026), from the memory controller.
REQ-006 wr_data  input  16  CPU store data, valid when out_sig=1.
REQ-007 rd_data  output  16  CPU load data for the input port.
REQ-008 stall  output  1  freezes the CPU while a port access cannot complete this cycle.
REQ-009 ext_in_data  input  16  external device input word.
REQ-010 ext_in_valid  input  1  external input word offered.
REQ-011 ext_in_ready  output  1  block accepts ext_in_data this cycle.
REQ-012 ext_out_data  output  16  word presented to external device.
REQ-013 ext_out_valid  output  1  ext_out_data holds an undelivered word.
REQ-014 ext_out_ready  input  1  external device takes ext_out_data this cycle.

Function
REQ-015 Input side SHALL be a 1-word buffer in_buf with flag in_full; states EMPTY (in_full=0) and FULL (in_full=1).
REQ-016 ext_in_ready SHALL equal (!in_full) | (in_sig & in_full); input transfer occurs on a clk edge when ext_in_valid & ext_in_ready.
REQ-017 EMPTY->FULL on input transfer; FULL->EMPTY on in_sig without input transfer; FULL stays FULL with new data on simultaneous in_sig and transfer (consume and refill in one cycle).
REQ-018 rd_data SHALL equal in_buf when in_sig & in_full, else 16'h0000 (combinational, zero added latency).
REQ-019 An in_sig while EMPTY SHALL assert stall and SHALL NOT capture pass-through data that cycle; the read completes the cycle after in_full rises (1-cycle minimum latency from ext_in_valid).
REQ-020 Output side (base build) SHALL be a 1-word buffer out_buf with flag out_full; ext_out_valid=out_full, ext_out_data=out_buf.
REQ-021 Output transfer occurs on a clk edge when ext_out_valid & ext_out_ready; it clears out_full unless a CPU write is accepted in the same cycle.
REQ-022 A CPU write (out_sig) SHALL be accepted when !out_full, or when out_full & ext_out_ready (drain and refill same edge); otherwise stall SHALL assert and out_buf SHALL remain unchanged.
REQ-023 stall SHALL equal (in_sig & !in_full) | (out_sig & !write_accept); purely combinational.
REQ-024 in_sig and out_sig asserted together SHALL be serviced independently; stall is the OR of both sides' conditions and neither side commits while stall=1.
REQ-025 ext_out_data SHALL not change while ext_out_valid=1 and ext_out_ready=0.

Reset
REQ-026 While rst_n=0: in_full=0, out_full=0, in_buf=0, out_buf=0, all FIFO pointers/count=0; hence rd_data=0, stall=in_sig? 0 gated: stall SHALL be 0, ext_in_ready=0, ext_out_valid=0, ext_out_data=0.
REQ-027 Reset mid-transfer SHALL discard any buffered words; first accept possible on the first clk edge after rst_n rises.

Configuration
REQ-028 Macro IO_PORT_OUTFIFO_EN: when defined, the output side SHALL be a 4-entry FIFO (2-bit read/write pointers wrapping 3->0, 3-bit count 0..4) replacing out_buf.
REQ-029 With IO_PORT_OUTFIFO_EN: ext_out_valid=(count!=0), ext_out_data=head entry; write accepted when count<4 or (count==4 & ext_out_ready); simultaneous push and pop leaves count unchanged; order strictly FIFO.
REQ-030 Without IO_PORT_OUTFIFO_EN: behaviour exactly per REQ-020..REQ-022; port list identical in both builds.

Verification
REQ-031 Reset then in_sig=1 with ext_in_valid=0 -> stall=1, rd_data=0; drive ext_in_data=16'h1234 valid one cycle -> next cycle stall=0, rd_data=16'h1234, then in_full=0.
REQ-032 in_full holding 16'hAAAA, in_sig=1 and ext_in_valid=1 data 16'h5555 same cycle -> rd_data=16'hAAAA, ext_in_ready=1, following read returns 16'h5555.
REQ-033 out_sig with wr_data=16'hBEEF, ext_out_ready=0 -> next cycle ext_out_valid=1, ext_out_data=16'hBEEF; second out_sig stalls (base build) until ext_out_ready=1, then 16'hBEEF delivered and new word loaded same edge.
REQ-034 IO_PORT_OUTFIFO_EN, ext_out_ready=0, five writes 1..5 -> writes 1-4 accepted, write 5 stalls; raise ext_out_ready -> delivered order 1,2,3,4,5, pointers wrap correctly.
REQ-035 Assert rst_n=0 asynchronously with both buffers full -> outputs zero immediately without clk edge; after release, ext_in_ready=1, ext_out_valid=0.
